// File: rtl/cdp_dp_cvtin_pipe.sv
// CDP input conversion: ((x - offset) * scale) >>> shift, round-half-up, saturate to signed 9 bits.
// Two-stage valid/ready pipeline with a per-layer saturated-element counter.
module cdp_dp_cvtin_pipe #(
  parameter int LANES = 8,
  parameter int IN_W  = 8,
  parameter int OUT_W = 9
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rstn,
  input  logic        nan_preproc_pvld,
  output logic        nan_preproc_prdy,
  input  logic [86:0] nan_preproc_pd,
  output logic        cvt2sync_pvld,
  input  logic        cvt2sync_prdy,
  output logic [94:0] cvt2sync_pd,
  input  logic [15:0] reg2dp_datin_offset,
  input  logic [15:0] reg2dp_datin_scale,
  input  logic [4:0]  reg2dp_datin_shifter,
  output logic [31:0] dp2reg_sat_num
);

  localparam int INFO_W = 23;
  localparam int D_W    = 17;
  localparam int P_W    = 33;
  localparam int R_W    = 34;
  localparam int CNT_W  = $clog2(LANES + 1);
  localparam logic signed [R_W-1:0] SAT_MAX = R_W'((1 <<< (OUT_W - 1)) - 1);
  localparam logic signed [R_W-1:0] SAT_MIN = R_W'(-(1 <<< (OUT_W - 1)));

  logic                   s1_vld;
  logic                   s2_vld;
  logic                   s1_adv;
  logic                   s2_adv;
  logic signed [P_W-1:0]  p_nxt [LANES];
  logic signed [P_W-1:0]  s1_p  [LANES];
  logic [INFO_W-1:0]      s1_info;
  logic [OUT_W-1:0]       lane_nxt [LANES];
  logic [LANES-1:0]       sat_nxt;
  logic [LANES*OUT_W-1:0] s2_lanes;
  logic [INFO_W-1:0]      s2_info;
  logic [LANES-1:0]       s2_sat;
  logic [31:0]            sat_cnt;
  logic [CNT_W-1:0]       sat_pop;
  logic [32:0]            cnt_sum;
  logic [31:0]            cnt_clamp;
  logic                   xfer;
  logic                   layer_end;

  assign s2_adv           = ~s2_vld | cvt2sync_prdy;
  assign s1_adv           = ~s1_vld | s2_adv;
  assign nan_preproc_prdy = s1_adv;
  assign cvt2sync_pvld    = s2_vld;
  assign cvt2sync_pd      = {s2_info, s2_lanes};

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [D_W-1:0] d;
    logic signed [R_W-1:0] rnd;
    logic signed [R_W-1:0] r;

    assign d        = D_W'($signed(nan_preproc_pd[i*IN_W +: IN_W])) - D_W'($signed(reg2dp_datin_offset));
    assign p_nxt[i] = P_W'(d) * P_W'($signed(reg2dp_datin_scale));

    // Adding half an LSB before the arithmetic shift makes ties go toward +inf.
    assign rnd = (reg2dp_datin_shifter == 5'd0) ? R_W'(s1_p[i])
               : R_W'(s1_p[i]) + (R_W'(1) <<< (reg2dp_datin_shifter - 5'd1));
    assign r   = rnd >>> reg2dp_datin_shifter;

    assign sat_nxt[i]  = (r > SAT_MAX) || (r < SAT_MIN);
    assign lane_nxt[i] = (r > SAT_MAX) ? SAT_MAX[OUT_W-1:0]
                       : (r < SAT_MIN) ? SAT_MIN[OUT_W-1:0]
                       : r[OUT_W-1:0];
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      s1_vld  <= 1'b0;
      s1_info <= '0;
      for (int i = 0; i < LANES; i++) s1_p[i] <= '0;
    end else if (s1_adv) begin
      s1_vld <= nan_preproc_pvld;
      if (nan_preproc_pvld) begin
        s1_info <= nan_preproc_pd[86:64];
        for (int i = 0; i < LANES; i++) s1_p[i] <= p_nxt[i];
      end
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      s2_vld   <= 1'b0;
      s2_lanes <= '0;
      s2_info  <= '0;
      s2_sat   <= '0;
    end else if (s2_adv) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_info <= s1_info;
        s2_sat  <= sat_nxt;
        for (int i = 0; i < LANES; i++) s2_lanes[i*OUT_W +: OUT_W] <= lane_nxt[i];
      end
    end
  end

  always_comb begin
    sat_pop = '0;
    for (int i = 0; i < LANES; i++) sat_pop = sat_pop + CNT_W'(s2_sat[i]);
  end

  assign xfer      = s2_vld & cvt2sync_prdy;
  assign layer_end = (s2_info[14:8] == 7'h7F);
  assign cnt_sum   = {1'b0, sat_cnt} + 33'(sat_pop);
  assign cnt_clamp = cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];

  // The layer-end beat's own flags are folded into the published count.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      sat_cnt        <= '0;
      dp2reg_sat_num <= '0;
    end else if (xfer) begin
      if (layer_end) begin
        dp2reg_sat_num <= cnt_clamp;
        sat_cnt        <= '0;
      end else begin
        sat_cnt <= cnt_clamp;
      end
    end
  end

endmodule

// File: doc/cdp_dp_cvtin_pipe.md
# cdp_dp_cvtin_pipe

Input-conversion stage of the CDP datapath, directly downstream of the NaN pre-process stage. It consumes the 87-bit beats that stage produces: eight signed int8 elements plus 23 info bits. Each element is converted as ((x − offset) × scale) >>> shift with round-half-up, then saturated to signed 9 bits. The stage is a two-deep valid/ready pipeline that feeds the CDP sync/LRN stages. It also counts saturated elements per layer for status readback.

## Interface
Parameters (fixed; no override expected):
- LANES, 8, elements per beat
- IN_W, 8, input element width (signed)
- OUT_W, 9, output element width (signed)

Ports:
- nvdla_core_clk  in  1  core clock; all state on its rising edge
- nvdla_core_rstn  in  1  synchronous, active-low reset
- nan_preproc_pvld  in  1  input beat valid
- nan_preproc_prdy  out  1  input beat ready
- nan_preproc_pd  in  87  [63:0] eight int8 lanes (lane i = [8i+7:8i]); [86:64] info
- cvt2sync_pvld  out  1  output beat valid
- cvt2sync_prdy  in  1  output beat ready
- cvt2sync_pd  out  95  [71:0] eight 9-bit lanes (lane i = [9i+8:9i]); [94:72] info, unmodified
- reg2dp_datin_offset  in  16  signed offset
- reg2dp_datin_scale  in  16  signed scale
- reg2dp_datin_shifter  in  5  right shift, 0..31
- dp2reg_sat_num  out  32  saturated-element count of the last completed layer

## Operation
- Config inputs are static while a layer is in flight. They are used combinationally at stage 1 and stage 2 and are not latched.
- Stage 1, on accept: d = x − offset (17-bit signed); p = d × scale (33-bit signed). Register p for all lanes, plus info.
- Stage 2: if shift = 0, r = p. Otherwise r = (p + 2^(shift−1)) >>> shift, arithmetic shift, so ties round toward +inf. Saturate r to [−256, 255] and set the per-lane sat flag if clamped. Register lanes, info and the sat flags.
- Layer-end beat: info[14:8] all ones, i.e. pd[78:72] = 7'h7F.
- Saturation count:
  - Running counter sat_cnt (32-bit) adds popcount(sat flags) on every output transfer (cvt2sync_pvld & cvt2sync_prdy).
  - sat_cnt clamps at 32'hFFFFFFFF and does not wrap.
  - On transfer of a layer-end beat, dp2reg_sat_num ← sat_cnt + this beat's count (clamped), and sat_cnt ← 0 in the same cycle.
- Info bits pass through both stages untouched.

## Timing
- Reset values:
  - s1_vld = 0, s2_vld = 0, so cvt2sync_pvld = 0.
  - cvt2sync_pd = 0, sat_cnt = 0, dp2reg_sat_num = 0.
  - nan_preproc_prdy = 1 in the first cycle after reset.
- Latency: an accepted beat appears on cvt2sync_pvld 2 cycles later with no backpressure. Throughput is 1 beat/cycle.
- Handshake:
  - s2_adv = ~s2_vld | cvt2sync_prdy.
  - s1_adv = ~s1_vld | s2_adv.
  - nan_preproc_prdy = s1_adv (combinational through both stages).
  - Stage registers load only when their own adv is high.
- While cvt2sync_pvld & ~cvt2sync_prdy, cvt2sync_pd is held stable and pvld is not withdrawn.
- No bubble under a continuous stream with prdy high. With prdy low, exactly two beats are buffered, then input stalls.
- Simultaneous accept and output transfer in one cycle: both occur and the pipeline shifts.
- Reset asserted mid-stream: all buffered beats are dropped and the pipeline returns to reset state at the next edge. sat_cnt is cleared; dp2reg_sat_num is cleared.

## Test plan
- Pass-through: offset=0, scale=1, shift=0; lanes 0x7F, 0x80, 0x00, 0xFF -> outputs 127 (0x07F), −128 (0x180), 0 (0x000), −1 (0x1FF); info echoed; pvld 2 cycles after accept.
- Offset/scale/round: offset=−128, scale=1, shift=0, x=127 -> 255 with no sat. Scale=4, shift=1, offset=0, x=100 -> 200. Scale=1, shift=1: x=3 -> 2 and x=−3 -> −1.
- Saturation/count: scale=16, shift=0. Layer of 3 beats, each with 2 lanes of x=100 (-> 255, sat) and 1 lane of x=−100 (-> −256, sat), last beat marked layer-end -> dp2reg_sat_num = 9 after the last transfer; sat_cnt = 0.
- Backpressure: 6 back-to-back beats, cvt2sync_prdy low for 5 cycles -> nan_preproc_prdy drops after 2 beats are buffered; pd stable while stalled; all 6 beats emerge in order with no loss or duplicates.
- Full throughput: 100 beats with prdy held high -> 100 transfers in 100 consecutive cycles after the 2-cycle fill.
- Reset mid-stream: two beats in flight, assert nvdla_core_rstn low for one cycle -> pvld = 0 and dp2reg_sat_num = 0 next cycle; prdy = 1; no stale beat is ever emitted.
